// File: rtl/timer_dev.sv
// Purpose : memory-mapped countdown timer (CTRL/PRESET/COUNT). It supports one-shot and auto-reload modes and has a maskable irq.
// Latency : reads are combinational on dev_addr. Writes take effect at the next rising edge. irq is registered.
// Backpres: none. A write is accepted on every cycle that we=1, and a read has no side effects.
// Ports   : clk, rst (async, active-high); dev_addr/we/dev_writeData (bus in);
//           dev_readData (read mux out); irq (irq_flag & CTRL.IM).
module timer_dev #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dev_addr,
  input  logic             we,
  input  logic [WIDTH-1:0] dev_writeData,
  output logic [WIDTH-1:0] dev_readData,
  output logic             irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       ctrl, ctrl_nxt;
  logic [WIDTH-1:0] preset, preset_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             irq_flag, flag_nxt;

  logic en;
  logic reload;
  logic wr_ctrl;
  logic wr_preset;

  assign en        = ctrl[0];
  // Mode 1x behaves as one-shot, so only the exact value 01 selects reload.
  assign reload    = (ctrl[2:1] == 2'b01);
  assign wr_ctrl   = we && (dev_addr == 2'd0);
  assign wr_preset = we && (dev_addr == 2'd1);

  always_comb begin
    state_nxt  = state;
    ctrl_nxt   = ctrl;
    preset_nxt = preset;
    count_nxt  = count;
    flag_nxt   = irq_flag;

    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
        // This ends the 1-cycle auto-reload pulse. On every other path into
        // LOAD, a CTRL write has already cleared the flag.
        flag_nxt  = 1'b0;
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;           // COUNT holds its value
        end else if (count <= WIDTH'(1)) begin
          count_nxt = '0;               // PRESET=0 lands here too, without wrapping
          state_nxt = S_INT;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
      S_INT: begin
        flag_nxt = 1'b1;
        if (reload) begin
          state_nxt = S_LOAD;
        end else begin
          ctrl_nxt[0] = 1'b0;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // CPU writes are applied last so they override the hardware En clear and
    // the hardware flag set in the same cycle.
    if (wr_ctrl) begin
      ctrl_nxt = dev_writeData[3:0];
      flag_nxt = 1'b0;
    end
    if (wr_preset) begin
      preset_nxt = dev_writeData;
      flag_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      irq_flag <= flag_nxt;
      // Registered from next-state values so that irq tracks irq_flag & IM
      // in the same cycle instead of lagging one cycle behind.
      irq      <= flag_nxt & ctrl_nxt[3];
    end
  end

  always_comb begin
    dev_readData = '0;
    case (dev_addr)
      2'd0:    dev_readData = WIDTH'(ctrl);
      2'd1:    dev_readData = preset;
      2'd2:    dev_readData = count;
      default: dev_readData = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev. The bench runs a vector table, several hand-written
// sequences for the corner cases, and randomized traffic that is checked
// against a rule-level model of the timer.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  timer_dev #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .dev_addr(addr), .we(we),
    .dev_writeData(wd), .dev_readData(rd), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    we = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one write cycle. Returns at the negedge after the write edge, with we low.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Reference model, stepped once per rising edge from the bus inputs.
  localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_FIRE = 3;
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  logic        m_flag, m_pulse;

  task automatic model_reset();
    m_phase = P_IDLE; m_ctrl = '0; m_preset = '0; m_count = '0;
    m_flag = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
    int          ph = m_phase;
    logic [3:0]  c  = m_ctrl;
    logic [31:0] p  = m_preset;
    logic [31:0] n  = m_count;
    logic        f  = m_flag;
    logic        pl = 1'b0;
    if (m_pulse) f = 1'b0;                 // auto-reload pulse lasts one cycle
    if (m_phase == P_IDLE) begin
      if (m_ctrl[0]) ph = P_LOAD;
    end else if (m_phase == P_LOAD) begin
      n = m_preset; ph = P_CNT;
    end else if (m_phase == P_CNT) begin
      if (!m_ctrl[0]) ph = P_IDLE;
      else if (m_count == 0 || m_count == 1) begin n = 0; ph = P_FIRE; end
      else n = m_count - 1;
    end else begin
      f = 1'b1;
      if (m_ctrl[2:1] == 2'b01) begin ph = P_LOAD; pl = 1'b1; end
      else begin c[0] = 1'b0; ph = P_IDLE; end
    end
    if (w && a == 2'd0) begin c = d[3:0]; f = 1'b0; end
    if (w && a == 2'd1) begin p = d; f = 1'b0; end
    m_phase = ph; m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_pulse = pl;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic found;
    logic saw_irq;

    // One-shot, PRESET=3: write PRESET, write CTRL=9 (E0), watch COUNT and irq, then clear.
    tbl[0]  = '{1'b1, 2'd1, 32'd3, 32'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 32'd9, 32'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 32'd0, 32'd3, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 32'd0, 32'd2, 1'b0};
    tbl[6]  = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 32'd0, 32'd8, 1'b1};
    tbl[9]  = '{1'b1, 2'd0, 32'd8, 32'd8, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 32'd0, 32'd8, 1'b0};

    // Test 1: reset state
    do_reset();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1 chk($sformatf("reset_rd%0d", a), rd, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // Test 2: table-driven one-shot
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      we = tbl[i].we; addr = tbl[i].addr; wd = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end
    we = 1'b0;

    // Test 3: auto-reload, pulses after E6, E11 and E16
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("ar_irq_E%0d", k), {31'd0, irq},
          (k == 6 || k == 11 || k == 16) ? 32'd1 : 32'd0);
      if (k == 7 || k == 12) chk($sformatf("ar_reload_E%0d", k), rd, 32'd3);
    end

    // Test 4: IM=0 masks irq; writing CTRL=8 clears the flag before unmasking
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    saw_irq = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (irq) saw_irq = 1'b1;
    end
    chk("mask_irq_low", {31'd0, saw_irq}, 32'd0);
    addr = 2'd0;
    #1 chk("mask_ctrl_en_cleared", rd, 32'd0);
    wr(2'd0, 32'h8);
    #1 chk("mask_irq_after_im", {31'd0, irq}, 32'd0);

    // Test 5: stop at COUNT=50, then restart from a new PRESET
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    addr = 2'd2;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      #1;
      if (rd == 32'd50) found = 1'b1;
    end
    chk("stop_reach50", {31'd0, found}, 32'd1);
    we = 1'b1; addr = 2'd0; wd = 32'h8;
    @(negedge clk);
    we = 1'b0; addr = 2'd2;
    #1 chk("stop_freeze_a", rd, 32'd49);
    repeat (3) @(negedge clk);
    #1 chk("stop_freeze_b", rd, 32'd49);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    @(negedge clk); #1 chk("restart_E1", rd, 32'd49);
    @(negedge clk); #1 chk("restart_E2", rd, 32'd5);
    @(negedge clk); #1 chk("restart_E3", rd, 32'd4);

    // Test 6: asynchronous reset mid-count; writes to addr2/3 are ignored
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    repeat (30) @(negedge clk);
    #1 chk("arst_pre_count", rd, 32'd72);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("arst_count", rd, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    addr = 2'd0;
    #1 chk("arst_ctrl", rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wr(2'd2, 32'd123);
    wr(2'd3, 32'd55);
    addr = 2'd2;
    #1 chk("ro_count", rd, 32'd0);
    addr = 2'd3;
    #1 chk("ro_addr3", rd, 32'd0);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int k = 0; k < 4000; k++) begin
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic        bad;
      @(negedge clk);
      w = ($urandom_range(0, 5) == 0);
      a = 2'($urandom_range(0, 3));
      d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      we = w; addr = a; wd = d;
      #1;
      bad = (rd !== model_read(a)) || (irq !== (m_flag & m_ctrl[3]));
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL rand%0d: rd=%0h irq=%0b, expected rd=%0h irq=%0b",
                 k, rd, irq, model_read(a), m_flag & m_ctrl[3]);
      end
      @(posedge clk);
      model_step(w, a, d);
    end
    @(negedge clk);
    we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
